branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-stage branch predictor with an integrated direct-mapped branch target buffer (BTB).
- Sits directly upstream of the branch control unit and drives its prediction inputs:
  - PCSrcPredF feeds the prediction logic.
  - PredPCTargetF is the PC-mux source selected when that prediction is taken.
- Each entry holds a valid bit, tag, target and 2-bit saturating counter, updated from resolved Execute-stage outcomes.
- PCSrcPredF must also be pipelined to Execute by the pipeline registers; it becomes PCSrcPredE there.

Parameters:
- IDX_BITS, 6, log2 of the BTB entry count (default 64 entries).
- WIDTH, 32, PC and target width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- PCF  input  WIDTH  Fetch-stage PC used for lookup.
- PCE  input  WIDTH  PC of the instruction in Execute.
- PCTargetE  input  WIDTH  resolved target of the Execute instruction.
- BranchE  input  1  Execute holds a valid control-transfer instruction (branch or jump), not flushed.
- PCSrcResE  input  1  resolved outcome of the Execute instruction: 1 = taken.
- StallE  input  1  Execute is stalled; suppresses the update.
- PCSrcPredF  output  1  predicted taken for PCF.
- PredPCTargetF  output  WIDTH  predicted target for PCF.

Behaviour:
- Clock and reset
  - One clock. Reset is asynchronous and active-high.
  - While reset is high, every entry is cleared: valid=0, tag=0, target=0, counter=2'b01 (weakly not-taken).
  - Outputs are combinational from table state, so during and after reset PCSrcPredF=0 and PredPCTargetF=0.
  - Reset asserted mid-update wins: the table is cleared and no write occurs that edge.
- Address split
  - idx = PC[IDX_BITS+1:2].
  - tag = PC[WIDTH-1:IDX_BITS+2].
  - PC[1:0] is ignored.
- Lookup (Fetch, combinational, zero latency)
  - hitF = valid[idxF] & (tag[idxF] == tagF).
  - PCSrcPredF = hitF & counter[idxF][1].
  - PredPCTargetF = hitF ? target[idxF] : 0.
- Update (Execute, registered): happens at a rising edge only when BranchE=1 and StallE=0.
  - Hit at idxE, resolved taken:
    - counter saturating-increments: 00→01→10→11, 11 holds.
    - target ← PCTargetE.
  - Hit, resolved not-taken:
    - counter saturating-decrements: 11→10→01→00, 00 holds.
    - target unchanged.
  - Miss (invalid or tag mismatch), resolved taken:
    - allocate: valid←1, tag←tagE, target←PCTargetE, counter←2'b10 (weakly taken).
    - This evicts any previous occupant.
  - Miss, resolved not-taken: no change; not-taken branches never allocate.
- Update suppression: when BranchE=0 or StallE=1, no table state changes.
- Simultaneous lookup and update
  - Same index in the same cycle: the Fetch lookup sees the pre-edge (old) contents. There is no write-through bypass.
  - The new value is visible to lookups from the cycle after the edge.
- Aliasing
  - Different PCs with equal idx but different tags conflict.
  - Lookup for the non-resident PC is a miss and predicts not-taken.
- Counter arithmetic: 2 bits, never wraps. Saturation is checked explicitly at 2'b11 and 2'b00.
- The block holds no other state. Target-match and rollback decisions are made downstream.

Test Plan:
- Reset then lookup: pulse reset; PCF=0x0000_0040 → PCSrcPredF=0, PredPCTargetF=0.
- Allocate then hit:
  - Cycle 1: BranchE=1, PCSrcResE=1, PCE=0x0000_0100, PCTargetE=0x0000_0080.
  - Following cycle: PCF=0x0000_0100 → PCSrcPredF=1, PredPCTargetF=0x0000_0080.
- Saturation:
  - Start from the allocated entry (counter 10). Apply 3 taken updates → counter 11, PCSrcPredF=1.
  - Then 2 not-taken updates → counter 01, PCSrcPredF=0.
  - Then 3 more not-taken updates → counter stays 00.
  - Finally 1 taken update → counter 01, prediction still 0.
- Aliasing:
  - Allocate PCE=0x0000_0100 taken.
  - Then allocate PCE=0x0000_0200 taken with target 0x0000_0300. Same idx for IDX_BITS=6, different tag.
  - Result: PCF=0x0000_0100 misses (PCSrcPredF=0); PCF=0x0000_0200 predicts 0x0000_0300.
- Stall, bypass and mid-run reset:
  - Update with StallE=1 → no change.
  - Update with lookup of the same index in the same cycle → old value returned, new value next cycle.
  - Assert reset asynchronously between edges after several allocations → outputs drop to 0 immediately and all prior entries miss afterwards.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Fetch-stage branch predictor with an integrated direct-mapped BTB.
//   Each of the 2**IDX_BITS entries holds a valid bit, a tag, a target and a
//   2-bit saturating counter.
//   - Lookup is combinational from the table state, keyed by PCF.
//   - Update is registered, keyed by PCE, using the resolved Execute outcome.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset, clears the table
//   PCF           in   Fetch PC used for lookup
//   PCE           in   PC of the instruction in Execute
//   PCTargetE     in   resolved target of the Execute instruction
//   BranchE       in   Execute holds a valid, unflushed control transfer
//   PCSrcResE     in   resolved outcome, 1 = taken
//   StallE        in   Execute stalled, suppresses the update
//   PCSrcPredF    out  predicted taken for PCF
//   PredPCTargetF out  predicted target for PCF (0 on a miss)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PCF,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             BranchE,
  input  logic             PCSrcResE,
  input  logic             StallE,
  output logic             PCSrcPredF,
  output logic [WIDTH-1:0] PredPCTargetF
);

  localparam int          TAG_W   = WIDTH - IDX_BITS - 2;
  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  // Table storage
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [WIDTH-1:0] r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  // Address split
  logic [IDX_BITS-1:0] w_idx_f;
  logic [TAG_W-1:0]    w_tag_f;
  logic [IDX_BITS-1:0] w_idx_e;
  logic [TAG_W-1:0]    w_tag_e;
  logic                w_unused_lowbits;

  assign w_idx_f = PCF[IDX_BITS+1:2];
  assign w_tag_f = PCF[WIDTH-1:IDX_BITS+2];
  assign w_idx_e = PCE[IDX_BITS+1:2];
  assign w_tag_e = PCE[WIDTH-1:IDX_BITS+2];

  // Byte offset within the instruction word plays no part in the lookup.
  assign w_unused_lowbits = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup: reads only pre-edge state, so there is no write-through.
  logic w_hit_f;

  assign w_hit_f       = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign PCSrcPredF    = w_hit_f && r_ctr[w_idx_f][1];
  assign PredPCTargetF = w_hit_f ? r_target[w_idx_f] : '0;

  // Execute-side hit detection and counter next value
  logic       w_hit_e;
  logic       w_upd_en;
  logic [1:0] w_ctr_old;
  logic [1:0] w_ctr_nxt;

  assign w_hit_e   = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
  assign w_upd_en  = BranchE && !StallE;
  assign w_ctr_old = r_ctr[w_idx_e];

  always_comb begin
    w_ctr_nxt = w_ctr_old;
    if (PCSrcResE) begin
      if (w_ctr_old != 2'b11) w_ctr_nxt = w_ctr_old + 2'd1;
    end else begin
      if (w_ctr_old != 2'b00) w_ctr_nxt = w_ctr_old - 2'd1;
    end
  end

  // Table update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i[IDX_BITS-1:0]]  <= 1'b0;
        r_tag[i[IDX_BITS-1:0]]    <= '0;
        r_target[i[IDX_BITS-1:0]] <= '0;
        r_ctr[i[IDX_BITS-1:0]]    <= 2'b01;
      end
    end else if (w_upd_en) begin
      if (w_hit_e) begin
        r_ctr[w_idx_e] <= w_ctr_nxt;
        if (PCSrcResE) r_target[w_idx_e] <= PCTargetE;
      end else if (PCSrcResE) begin
        // Taken miss allocates, evicting whatever occupied the index.
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= PCTargetE;
        r_ctr[w_idx_e]    <= 2'b10;
      end
    end
  end

endmodule
